// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmit byte path
// between NREQ requesters, paced against tx_full with a mid-packet stall timeout.
module uart_tx_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TW          = 10
) (
    input  logic              clk96,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_write,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              timeout_err
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    rr_q, rr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_write_q, tx_write_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;

    logic          found_s;
    logic [1:0]    pick_s;
    logic          grant_valid_s;
    logic          lane_last_s;
    logic [7:0]    lane_byte_s;
    logic          timeout_hit_s;
    logic          xfer_s;
    logic [1:0]    next_ptr_s;

    // State register: all flops, asynchronous active-low reset.
    always_ff @(posedge clk96 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= 2'd0;
            rr_q          <= 2'd0;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_write_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_write_q    <= tx_write_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Round-robin search from rr_q; iterating backwards lets the nearest valid index win.
    always_comb begin
        found_s = 1'b0;
        pick_s  = rr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            found_s = found_s | 1'(req_valid >> ((int'(rr_q) + k) % NREQ));
            pick_s  = 1'(req_valid >> ((int'(rr_q) + k) % NREQ)) ? 2'((int'(rr_q) + k) % NREQ) : pick_s;
        end
    end

    // Granted lane selection and transfer qualification; the timeout pre-empts a late byte.
    always_comb begin
        grant_valid_s = 1'(req_valid >> grant_q);
        lane_last_s   = 1'(req_last >> grant_q);
        lane_byte_s   = 8'(req_data >> {grant_q, 3'b000});
        timeout_hit_s = (state_q == S_STREAM) && (cnt_q == TW'(TIMEOUT_CYC - 1));
        xfer_s        = (state_q == S_STREAM) && grant_valid_s && !tx_full && !tx_write_q && !timeout_hit_s;
        next_ptr_s    = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
    end

    // Next-state logic: grant in IDLE, stream until last byte or timeout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (found_s) begin
                    state_d = S_STREAM;
                    grant_d = pick_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (timeout_hit_s) begin
                    state_d = S_IDLE;
                    rr_d    = next_ptr_s;
                    cnt_d   = '0;
                end else if (xfer_s) begin
                    cnt_d = '0;
                    if (lane_last_s) begin
                        state_d = S_IDLE;
                        rr_d    = next_ptr_s;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: one-hot ready on the granted lane, registered write strobe and status.
    always_comb begin
        req_ready     = {{(NREQ-1){1'b0}}, xfer_s} << grant_q;
        tx_write_d    = xfer_s;
        tx_data_d     = xfer_s ? lane_byte_s : tx_data_q;
        busy_d        = (state_d == S_STREAM);
        timeout_err_d = timeout_hit_s;
    end

    assign tx_data     = tx_data_q;
    assign tx_write    = tx_write_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: lane-driven packets, write log, hand-computed expectations.
module tb_uart_tx_arbiter;

    logic        clk96 = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_last, req_ready, t_req_ready;
    logic [15:0] req_data;
    logic        tx_full;
    logic [7:0]  tx_data, t_tx_data;
    logic        tx_write, t_tx_write, busy, t_busy, timeout_err, t_timeout_err;
    logic [1:0]  grant_id, t_grant_id;

    always #5 clk96 = ~clk96;

    uart_tx_arbiter #(.NREQ(2), .TIMEOUT_CYC(1023), .TW(10)) dut (
        .clk96(clk96), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full), .tx_data(tx_data),
        .tx_write(tx_write), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NREQ(2), .TIMEOUT_CYC(16), .TW(10)) dut_t (
        .clk96(clk96), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(t_req_ready), .tx_full(tx_full), .tx_data(t_tx_data),
        .tx_write(t_tx_write), .busy(t_busy), .grant_id(t_grant_id), .timeout_err(t_timeout_err)
    );

    // Requester lanes: byte tables, lengths and read positions.
    logic [7:0] lb [2][8];
    logic       ll [2][8];
    int         ln [2];
    int         lp [2];
    logic       en [2];
    logic       lloop [2];
    logic       sel_t;
    logic       mon3;
    logic [1:0] acc;

    logic [7:0] ob[$];
    logic [1:0] og[$];
    int         oc[$];
    logic [7:0] tob[$];
    int         toc[$];
    int         cyc_cnt, consec, ffail, bad3, terr_m, terr_t, terr_cyc;
    logic       terr_busy, prev_wr;
    int         checks, errors;

    // Lane outputs follow the current read position of each requester.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i]       = en[i] && (lp[i] < ln[i]);
            req_data[8*i +: 8] = (lp[i] < 8) ? lb[i][lp[i]] : 8'h00;
            req_last[i]        = (lp[i] < 8) ? ll[i][lp[i]] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk96);
        if (tx_write) begin
            ob.push_back(tx_data);
            og.push_back(grant_id);
            oc.push_back(cyc_cnt);
        end
        if (tx_write && prev_wr) consec++;
        prev_wr = tx_write;
        if (t_tx_write) begin
            tob.push_back(t_tx_data);
            toc.push_back(cyc_cnt);
        end
        if (timeout_err) terr_m++;
        if (t_timeout_err) begin
            terr_t++;
            terr_cyc  = cyc_cnt;
            terr_busy = t_busy;
        end
        if (tx_full && (req_ready != 2'b00)) ffail++;
        if (mon3 && req_ready[1] && (lp[0] < ln[0])) bad3++;
        acc = req_valid & (sel_t ? t_req_ready : req_ready);
        @(posedge clk96);
        cyc_cnt++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                lp[i]++;
                if (lloop[i] && lp[i] >= ln[i]) lp[i] = 0;
            end
        end
    endtask

    task automatic clr_lanes();
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; lloop[i] = 1'b0; ln[i] = 0; lp[i] = 0;
            for (int j = 0; j < 8; j++) begin
                lb[i][j] = 8'h00; ll[i][j] = 1'b0;
            end
        end
    endtask

    task automatic clr_logs();
        ob.delete(); og.delete(); oc.delete(); tob.delete(); toc.delete();
        terr_m = 0; terr_t = 0; terr_cyc = 0; ffail = 0; bad3 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_full = 1'b0; sel_t = 1'b0; mon3 = 1'b0;
        clr_lanes();
        tick(); tick();
        rst_n = 1'b1;
        clr_logs();
    endtask

    task automatic wait_lp(input int lane, input int val, input int budget);
        int n = 0;
        while (lp[lane] < val && n < budget) begin tick(); n++; end
        if (lp[lane] < val) chk("wait_lane_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_log(input int cnt, input int budget, input logic use_t);
        int n = 0;
        while ((use_t ? tob.size() : ob.size()) < cnt && n < budget) begin tick(); n++; end
        if ((use_t ? tob.size() : ob.size()) < cnt) chk("wait_write_log", 32'd0, 32'd1);
    endtask

    logic [7:0] e2b [8];
    logic [1:0] e2g [8];

    initial begin
        checks = 0; errors = 0; cyc_cnt = 0; consec = 0; prev_wr = 1'b0; acc = 2'b00;
        terr_busy = 1'b0;
        clr_lanes(); clr_logs();
        rst_n = 1'b0; tx_full = 1'b0; sel_t = 1'b0; mon3 = 1'b0;
        // Reset state, with both lanes presenting data.
        ln[0] = 1; ln[1] = 1; en[0] = 1'b1; en[1] = 1'b1;
        tick(); tick();
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_write", tx_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);

        // Single requester, 3-byte packet.
        do_reset();
        lb[0][0] = 8'h90; lb[0][1] = 8'h3C; lb[0][2] = 8'h7F; ll[0][2] = 1'b1; ln[0] = 3;
        en[0] = 1'b1;
        wait_lp(0, 1, 20);
        chk("t1_busy_mid", busy, 1'b1);
        wait_lp(0, 3, 40);
        chk("t1_last_write", tx_write, 1'b1);
        chk("t1_last_data", tx_data, 8'h7F);
        chk("t1_busy_after", busy, 1'b0);
        tick();
        chk("t1_count", ob.size(), 3);
        if (ob.size() == 3) begin
            chk("t1_b0", ob[0], 8'h90);
            chk("t1_b1", ob[1], 8'h3C);
            chk("t1_b2", ob[2], 8'h7F);
            chk("t1_gap01", oc[1] - oc[0], 2);
            chk("t1_gap12", oc[2] - oc[1], 2);
            chk("t1_grant", og[2], 2'd0);
        end
        chk("t1_tx_data_hold", tx_data, 8'h7F);

        // Two requesters held continuously with 2-byte packets.
        do_reset();
        lb[0][0] = 8'hA1; lb[0][1] = 8'hA2; ll[0][1] = 1'b1; ln[0] = 2; lloop[0] = 1'b1;
        lb[1][0] = 8'hB1; lb[1][1] = 8'hB2; ll[1][1] = 1'b1; ln[1] = 2; lloop[1] = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        e2b = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hA1, 8'hA2, 8'hB1, 8'hB2};
        e2g = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        wait_log(8, 100, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i < ob.size()) begin
                chk($sformatf("t2_byte%0d", i), ob[i], e2b[i]);
                chk($sformatf("t2_grant%0d", i), og[i], e2g[i]);
            end
        end

        // Lane1 arrives while lane0 packet is in progress.
        do_reset();
        lb[0][0] = 8'h10; lb[0][1] = 8'h11; lb[0][2] = 8'h12; ll[0][2] = 1'b1; ln[0] = 3;
        lb[1][0] = 8'h20; ll[1][0] = 1'b1; ln[1] = 1;
        mon3 = 1'b1;
        en[0] = 1'b1;
        wait_lp(0, 1, 20);
        en[1] = 1'b1;
        wait_lp(1, 1, 40);
        tick(); tick();
        mon3 = 1'b0;
        chk("t3_lane1_held_off", bad3, 0);
        chk("t3_count", ob.size(), 4);
        if (ob.size() == 4) begin
            chk("t3_b2", ob[2], 8'h12);
            chk("t3_b3", ob[3], 8'h20);
            chk("t3_grant3", og[3], 2'd1);
            chk("t3_handover_gap", oc[3] - oc[2], 2);
        end

        // tx_full stall of 20 cycles mid-packet.
        do_reset();
        lb[0][0] = 8'h30; lb[0][1] = 8'h31; lb[0][2] = 8'h32; ll[0][2] = 1'b1; ln[0] = 3;
        en[0] = 1'b1;
        wait_lp(0, 1, 20);
        tx_full = 1'b1;
        repeat (20) tick();
        chk("t4_no_write_in_stall", ob.size(), 1);
        chk("t4_no_accept_in_stall", lp[0], 1);
        chk("t4_ready_low_in_stall", ffail, 0);
        tx_full = 1'b0;
        tick();
        chk("t4_resume_write", tx_write, 1'b1);
        chk("t4_resume_data", tx_data, 8'h31);
        wait_lp(0, 3, 20);
        tick(); tick();
        chk("t4_count", ob.size(), 3);
        chk("t4_no_timeout", terr_m, 0);

        // Stalled requester revoked by timeout (TIMEOUT_CYC=16 instance).
        do_reset();
        sel_t = 1'b1;
        lb[0][0] = 8'hF0; ln[0] = 1;
        lb[1][0] = 8'h55; ll[1][0] = 1'b1; ln[1] = 1;
        en[0] = 1'b1; en[1] = 1'b1;
        wait_log(2, 80, 1'b1);
        chk("t5_err_pulses", terr_t, 1);
        chk("t5_busy_at_err", terr_busy, 1'b0);
        chk("t5_grant_next", t_grant_id, 2'd1);
        if (tob.size() >= 2) begin
            chk("t5_b0", tob[0], 8'hF0);
            chk("t5_b1", tob[1], 8'h55);
            chk("t5_err_delay", terr_cyc - toc[0], 16);
            chk("t5_regrant_gap", toc[1] - terr_cyc, 2);
        end

        // Reset asserted mid-packet, then pointer restarts at lane0.
        do_reset();
        lb[1][0] = 8'h40; lb[1][1] = 8'h41; lb[1][2] = 8'h42; ll[1][2] = 1'b1; ln[1] = 3;
        en[1] = 1'b1;
        wait_lp(1, 1, 20);
        chk("t6_write_before_rst", tx_write, 1'b1);
        chk("t6_grant_before_rst", grant_id, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_write", tx_write, 1'b0);
        chk("t6_rst_tx_data", tx_data, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_grant", grant_id, 2'd0);
        clr_lanes();
        lb[0][0] = 8'h60; ll[0][0] = 1'b1; ln[0] = 1;
        lb[1][0] = 8'h50; ll[1][0] = 1'b1; ln[1] = 1;
        en[0] = 1'b1; en[1] = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        clr_logs();
        wait_log(2, 30, 1'b0);
        if (ob.size() >= 2) begin
            chk("t6_first_byte", ob[0], 8'h60);
            chk("t6_first_grant", og[0], 2'd0);
            chk("t6_second_byte", ob[1], 8'h50);
            chk("t6_second_grant", og[1], 2'd1);
        end

        chk("no_back_to_back_write", consec, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte path (uart_tx write port inside the UART subsystem) between NREQ independent requesters, e.g. MIDI-thru echo and status/debug reporter.
- Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until its last byte is accepted, so bytes from different packets never interleave.
- Paces writes against the transmit FIFO full flag and recovers from a stalled requester via a timeout.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT_CYC, 1023, idle cycles allowed mid-packet before the grant is revoked (>=2).
- TW, 10, timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- clk96  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i has a byte on its lane.
- req_data  input  8*NREQ  byte lanes; lane i = bits [8i+7:8i].
- req_last  input  NREQ  byte on lane i is the last of its packet.
- req_ready  output  NREQ  byte on lane i accepted this cycle (combinational).
- tx_full  input  1  transmit FIFO full (uart_tx buffer_full).
- tx_data  output  8  byte to transmit FIFO (registered).
- tx_write  output  1  one-cycle write strobe to transmit FIFO (registered).
- busy  output  1  a packet is in progress.
- grant_id  output  2  index of current/last granted requester.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst_n low, async): state IDLE; tx_data=0, tx_write=0, busy=0, grant_id=0, timeout_err=0, rr pointer=0, timeout counter=0; req_ready=0 throughout.
- States: IDLE, STREAM.
- IDLE:
  - Each cycle, search for valid requesters starting at the rr pointer, wrapping modulo NREQ.
  - If any are found, register grant_id = first valid index, set busy=1, go to STREAM next cycle. No byte is accepted in the grant cycle.
- STREAM:
  - req_ready[grant_id] = req_valid[grant_id] & ~tx_full & ~tx_write. All other req_ready bits are 0.
  - At most one byte is transferred every 2 cycles; the tx_write gap absorbs the one-cycle latency of tx_full.
  - On transfer: next cycle tx_write=1 and tx_data=lane byte; timeout counter cleared.
  - Transfer with req_last=1: return to IDLE, busy=0, rr pointer = grant_id+1 mod NREQ. A new grant may be issued in the following cycle.
  - No transfer: counter increments. When it reaches TIMEOUT_CYC: go to IDLE, timeout_err=1 for one cycle, busy=0, rr pointer advances as above, counter cleared.
  - tx_full held high also counts toward the timeout, so the timeout bounds total stall time.
- Single-byte packet (valid+last together): grant cycle, one transfer, back to IDLE. Minimum 3 cycles per packet.
- Requesters deasserting valid while not granted: no effect, no latching.
- Valid asserted on the granted lane at the same edge the timeout fires: the timeout wins and no byte is accepted.
- tx_write is never high in two consecutive cycles; tx_data holds its last value when tx_write=0.
- grant_id holds its value in IDLE until the next grant.
- Reset asserted mid-packet: immediate return to reset values, partial packet abandoned, and tx_write drops asynchronously.

Test Plan:
- Reset then req_valid=01, lane0 bytes 0x90,0x3C,0x7F (last on 0x7F), tx_full=0 -> tx_write pulses every 2nd cycle carrying 0x90,0x3C,0x7F in order; busy high from grant until cycle after last; grant_id=0.
- Both lanes valid with 2-byte packets (lane0 0xA1,0xA2; lane1 0xB1,0xB2), held continuously -> output sequence A1,A2,B1,B2,A1,A2..., no interleaving; grant_id alternates 0,1.
- Lane0 packet in progress while lane1 asserts valid -> lane1 req_ready stays 0 until lane0 last accepted, then lane1 is granted next.
- tx_full forced high for 20 cycles mid-packet -> no tx_write, req_ready=0; resumes with next byte one cycle after tx_full low; no timeout_err.
- Lane0 sends 0xF0 then drops valid without last, TIMEOUT_CYC=16 -> timeout_err single pulse 16 cycles after transfer, busy=0, pending lane1 granted next.
- Assert rst_n low during a 3-byte packet after the first byte -> outputs return to reset values immediately; after release, pointer=0 and lane0 is granted first if both lanes are valid.
